// File: rtl/pipe_flow_ctrl_pkg.sv
// rtl/pipe_flow_ctrl_pkg.sv - shared encodings for the pipeline flow controller
// Purpose: next_pc_sel encodings, MDU timer state, cycle-mode enum and the
// default exception entry address shared by the controller and its timer.
package pipe_ctrl_pkg;

  localparam logic [1:0]  PCSEL_SEQ     = 2'd0;
  localparam logic [1:0]  PCSEL_HANDLER = 2'd1;
  localparam logic [1:0]  PCSEL_EPC     = 2'd2;

  localparam logic [31:0] DEFAULT_HANDLER_PC = 32'h0000_4180;

  typedef enum logic {
    MDU_IDLE,
    MDU_BUSY
  } mdu_state_t;

  // Cycle mode after priority resolution: exception > eret > stall > run.
  typedef enum logic [1:0] {
    MODE_RUN,
    MODE_STALL,
    MODE_ERET,
    MODE_EXC
  } cycle_mode_t;

endpackage

// File: rtl/pipe_flow_ctrl_if.sv
// rtl/pipe_flow_ctrl_if.sv - pipeline enable/flush/redirect bundle
// Purpose: groups the per-stage register controls and the PC redirect.
// Signals: pc_en, fd_en, de_en (enables); fd_flush, de_flush, em_flush,
// mw_flush (clear-to-bubble); next_pc_sel (PC source); redirect_pc (target).
// Modports: master = controller (drives), slave = pipeline (consumes).
interface pipe_flow_ctrl_if;
  import pipe_ctrl_pkg::*;

  logic        pc_en;
  logic        fd_en;
  logic        de_en;
  logic        fd_flush;
  logic        de_flush;
  logic        em_flush;
  logic        mw_flush;
  logic [1:0]  next_pc_sel;
  logic [31:0] redirect_pc;

  modport master (
    output pc_en, fd_en, de_en,
    output fd_flush, de_flush, em_flush, mw_flush,
    output next_pc_sel, redirect_pc
  );

  modport slave (
    input pc_en, fd_en, de_en,
    input fd_flush, de_flush, em_flush, mw_flush,
    input next_pc_sel, redirect_pc
  );

endinterface

// File: rtl/pipe_flow_ctrl_mdu.sv
// rtl/pipe_flow_ctrl_mdu.sv - multiply/divide unit occupancy timer
// Purpose: tracks how long the MDU stays occupied after a mult/div starts.
// Ports: clk, reset_n (async active-low); start (mult/div starts in E);
// is_div (1 = div, 0 = mult); cancel (exception this cycle, drops the start);
// busy (high for exactly MULT_CYCLES or DIV_CYCLES cycles after the start edge).
module mdu_busy_timer
  import pipe_ctrl_pkg::*;
#(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic clk,
  input  logic reset_n,
  input  logic start,
  input  logic is_div,
  input  logic cancel,
  output logic busy
);

  mdu_state_t state, state_nxt;
  logic [3:0] cnt, cnt_nxt;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= MDU_IDLE;
      cnt   <= 4'd0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    case (state)
      MDU_IDLE: begin
        if (start && !cancel) begin
          state_nxt = MDU_BUSY;
          cnt_nxt   = is_div ? 4'(DIV_CYCLES) : 4'(MULT_CYCLES);
        end
      end
      MDU_BUSY: begin
        // A start while busy cannot happen (hazard logic holds it in D),
        // and an exception does not abort the running operation.
        cnt_nxt = cnt - 4'd1;
        if (cnt == 4'd1) begin
          state_nxt = MDU_IDLE;
        end
      end
      default: begin
        state_nxt = MDU_IDLE;
        cnt_nxt   = 4'd0;
      end
    endcase
  end

  assign busy = (state == MDU_BUSY);

endmodule

// File: rtl/pipe_flow_ctrl.sv
// rtl/pipe_flow_ctrl.sv - central pipeline flow controller
// Purpose: resolves exception, eret, stall and run into per-stage enables,
// flushes and the PC redirect; owns the MDU timer and event counters.
// Ports: clk, reset_n (async active-low); hz_stall (data hazard in D);
// md_use_d (D uses MDU); mdu_start_e, mdu_div_e (mult/div starting in E);
// req (exception from CP0); eret_m (eret in M); epc (return address);
// ctl (enables/flushes/redirect); mdu_busy; stall_cnt, flush_cnt (saturating).
module pipe_flow_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int          MULT_CYCLES = 5,
  parameter int          DIV_CYCLES  = 10,
  parameter logic [31:0] HANDLER_PC  = DEFAULT_HANDLER_PC
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic                     hz_stall,
  input  logic                     md_use_d,
  input  logic                     mdu_start_e,
  input  logic                     mdu_div_e,
  input  logic                     req,
  input  logic                     eret_m,
  input  logic [31:0]              epc,
  pipe_flow_ctrl_if.master         ctl,
  output logic                     mdu_busy,
  output logic [31:0]              stall_cnt,
  output logic [31:0]              flush_cnt
);

  cycle_mode_t mode;
  logic        stall;

  mdu_busy_timer #(
    .MULT_CYCLES (MULT_CYCLES),
    .DIV_CYCLES  (DIV_CYCLES)
  ) u_mdu (
    .clk     (clk),
    .reset_n (reset_n),
    .start   (mdu_start_e),
    .is_div  (mdu_div_e),
    .cancel  (req),
    .busy    (mdu_busy)
  );

  // An MDU user in D must wait both for a running op and for one starting in E.
  assign stall = (hz_stall | (md_use_d & (mdu_start_e | mdu_busy))) & ~req & ~eret_m;

  always_comb begin
    if (req)         mode = MODE_EXC;
    else if (eret_m) mode = MODE_ERET;
    else if (stall)  mode = MODE_STALL;
    else             mode = MODE_RUN;
  end

  // Outputs are forced inactive while reset is asserted.
  always_comb begin
    ctl.pc_en       = 1'b0;
    ctl.fd_en       = 1'b0;
    ctl.de_en       = 1'b0;
    ctl.fd_flush    = 1'b0;
    ctl.de_flush    = 1'b0;
    ctl.em_flush    = 1'b0;
    ctl.mw_flush    = 1'b0;
    ctl.next_pc_sel = PCSEL_SEQ;
    ctl.redirect_pc = 32'd0;
    if (reset_n) begin
      ctl.pc_en = 1'b1;
      ctl.fd_en = 1'b1;
      ctl.de_en = 1'b1;
      case (mode)
        MODE_EXC: begin
          ctl.fd_flush    = 1'b1;
          ctl.de_flush    = 1'b1;
          ctl.em_flush    = 1'b1;
          ctl.mw_flush    = 1'b1;
          ctl.next_pc_sel = PCSEL_HANDLER;
          ctl.redirect_pc = HANDLER_PC;
        end
        MODE_ERET: begin
          // eret itself sits in M and must retire, so M/W is kept.
          ctl.fd_flush    = 1'b1;
          ctl.de_flush    = 1'b1;
          ctl.em_flush    = 1'b1;
          ctl.next_pc_sel = PCSEL_EPC;
          ctl.redirect_pc = epc;
        end
        MODE_STALL: begin
          ctl.pc_en    = 1'b0;
          ctl.fd_en    = 1'b0;
          ctl.de_flush = 1'b1;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      stall_cnt <= 32'd0;
      flush_cnt <= 32'd0;
    end else begin
      if (mode == MODE_STALL && stall_cnt != 32'hFFFF_FFFF) begin
        stall_cnt <= stall_cnt + 32'd1;
      end
      if ((mode == MODE_EXC || mode == MODE_ERET) && flush_cnt != 32'hFFFF_FFFF) begin
        flush_cnt <= flush_cnt + 32'd1;
      end
    end
  end

endmodule

// File: tb/tb_pipe_flow_ctrl.sv
// tb/tb_pipe_flow_ctrl.sv - self-checking bench for pipe_flow_ctrl
module tb_pipe_flow_ctrl;
  import pipe_ctrl_pkg::*;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        hz_stall = 1'b0;
  logic        md_use_d = 1'b0;
  logic        mdu_start_e = 1'b0;
  logic        mdu_div_e = 1'b0;
  logic        req = 1'b0;
  logic        eret_m = 1'b0;
  logic [31:0] epc = 32'd0;
  logic        mdu_busy;
  logic [31:0] stall_cnt, flush_cnt;

  pipe_flow_ctrl_if pif ();

  pipe_flow_ctrl u_dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .hz_stall    (hz_stall),
    .md_use_d    (md_use_d),
    .mdu_start_e (mdu_start_e),
    .mdu_div_e   (mdu_div_e),
    .req         (req),
    .eret_m      (eret_m),
    .epc         (epc),
    .ctl         (pif),
    .mdu_busy    (mdu_busy),
    .stall_cnt   (stall_cnt),
    .flush_cnt   (flush_cnt)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Reference state: cycles of MDU occupancy still ahead and event totals.
  int          busy_left = 0;
  logic [31:0] stall_exp = 32'd0;
  logic [31:0] flush_exp = 32'd0;
  logic        obs_pc_en;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    busy_left = 0;
    stall_exp = 32'd0;
    flush_exp = 32'd0;
  endtask

  // One clock cycle: apply inputs, check combinational outputs, let the
  // edge happen, then check the registered state against the model.
  task automatic step(input logic hz, input logic mu, input logic st, input logic dv,
                      input logic rq, input logic er, input logic [31:0] ep);
    logic        busy_now, stall_now;
    logic        e_pc, e_fd, e_de, e_ff, e_df, e_ef, e_mf;
    logic [1:0]  e_sel;
    logic [31:0] e_rpc;
    @(negedge clk);
    hz_stall = hz; md_use_d = mu; mdu_start_e = st; mdu_div_e = dv;
    req = rq; eret_m = er; epc = ep;
    #1;
    busy_now  = (busy_left > 0);
    stall_now = (hz || (mu && (st || busy_now))) && !rq && !er;
    e_pc = 1; e_fd = 1; e_de = 1; e_ff = 0; e_df = 0; e_ef = 0; e_mf = 0;
    e_sel = 2'd0; e_rpc = 32'd0;
    if (rq) begin
      {e_ff, e_df, e_ef, e_mf} = 4'b1111; e_sel = 2'd1; e_rpc = 32'h0000_4180;
    end else if (er) begin
      {e_ff, e_df, e_ef} = 3'b111; e_sel = 2'd2; e_rpc = ep;
    end else if (stall_now) begin
      e_pc = 0; e_fd = 0; e_df = 1;
    end
    obs_pc_en = pif.pc_en;
    check("pc_en",       32'(pif.pc_en),       32'(e_pc));
    check("fd_en",       32'(pif.fd_en),       32'(e_fd));
    check("de_en",       32'(pif.de_en),       32'(e_de));
    check("fd_flush",    32'(pif.fd_flush),    32'(e_ff));
    check("de_flush",    32'(pif.de_flush),    32'(e_df));
    check("em_flush",    32'(pif.em_flush),    32'(e_ef));
    check("mw_flush",    32'(pif.mw_flush),    32'(e_mf));
    check("next_pc_sel", 32'(pif.next_pc_sel), 32'(e_sel));
    check("redirect_pc", pif.redirect_pc,      e_rpc);
    @(posedge clk);
    if (rq || er) begin
      if (flush_exp != 32'hFFFF_FFFF) flush_exp = flush_exp + 1;
    end else if (stall_now) begin
      if (stall_exp != 32'hFFFF_FFFF) stall_exp = stall_exp + 1;
    end
    if (busy_left > 0)     busy_left = busy_left - 1;
    else if (st && !rq)    busy_left = dv ? 10 : 5;
    #1;
    check("mdu_busy",  32'(mdu_busy), 32'(busy_left > 0));
    check("stall_cnt", stall_cnt, stall_exp);
    check("flush_cnt", flush_cnt, flush_exp);
  endtask

  initial begin
    int busy_hi, pc_lo;
    logic [31:0] s_before;

    // Held in reset: everything inactive.
    #12;
    check("rst_pc_en",    32'(pif.pc_en),    32'd0);
    check("rst_de_en",    32'(pif.de_en),    32'd0);
    check("rst_mdu_busy", 32'(mdu_busy),     32'd0);
    @(negedge clk);
    reset_n = 1'b1;
    model_reset();

    // Run with idle inputs.
    repeat (2) step(0, 0, 0, 0, 0, 0, 32'd0);
    check("t1_stall_cnt", stall_cnt, 32'd0);
    check("t1_flush_cnt", flush_cnt, 32'd0);

    // Divide start with a dependent MDU user held in D.
    busy_hi = 0; pc_lo = 0;
    step(0, 1, 1, 1, 0, 0, 32'd0);
    if (!obs_pc_en) pc_lo++;
    if (mdu_busy) busy_hi++;
    repeat (13) begin
      step(0, 1, 0, 0, 0, 0, 32'd0);
      if (!obs_pc_en) pc_lo++;
      if (mdu_busy) busy_hi++;
    end
    check("t2_busy_cycles", 32'(busy_hi), 32'd10);
    check("t2_pc_lo",       32'(pc_lo),   32'd11);
    check("t2_stall_cnt",   stall_cnt,    32'd11);

    // Mult start cancelled by an exception in the same cycle.
    step(0, 0, 1, 0, 1, 0, 32'd0);
    check("t3_mdu_busy",  32'(mdu_busy), 32'd0);
    check("t3_flush_cnt", flush_cnt,     32'd1);

    // Hazard stall suppressed by eret.
    s_before = stall_cnt;
    step(1, 0, 0, 0, 0, 1, 32'h3010);
    check("t4_stall_same", stall_cnt, s_before);

    // Exception and eret together: exception wins, one flush counted.
    step(0, 0, 0, 0, 1, 1, 32'h5555);
    check("t5_flush_cnt", flush_cnt, 32'd3);

    // Randomized traffic; the bench never starts the MDU while it is busy.
    for (int i = 0; i < 400; i++) begin
      logic hz, mu, st, dv, rq, er;
      hz = ($urandom_range(0, 9) < 2);
      mu = ($urandom_range(0, 9) < 4);
      st = (busy_left == 0) && ($urandom_range(0, 99) < 15);
      dv = $urandom_range(0, 1) == 1;
      rq = ($urandom_range(0, 99) < 5);
      er = ($urandom_range(0, 99) < 5);
      step(hz, mu, st, dv, rq, er, $urandom());
    end

    // Reset pulsed in the middle of a divide.
    step(0, 0, 1, 1, 0, 0, 32'd0);
    step(0, 1, 0, 0, 0, 0, 32'd0);
    step(0, 1, 0, 0, 0, 0, 32'd0);
    check("t6_busy_before", 32'(mdu_busy), 32'd1);
    #2;
    reset_n = 1'b0;
    #1;
    check("t6_mdu_busy",  32'(mdu_busy),  32'd0);
    check("t6_stall_cnt", stall_cnt,      32'd0);
    check("t6_flush_cnt", flush_cnt,      32'd0);
    check("t6_pc_en",     32'(pif.pc_en), 32'd0);
    model_reset();
    @(negedge clk);
    reset_n = 1'b1;
    repeat (3) step(0, 1, 0, 0, 0, 0, 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/pipe_flow_ctrl.md
# pipe_flow_ctrl

Central pipeline flow controller for the five-stage MIPS core with precise exceptions. It combines hazard stalls, multiply/divide-unit occupancy, exception requests and `eret` into per-stage enable and flush signals for the F/D, D/E, E/M and M/W pipeline registers. It also drives the PC redirect. It owns the MDU busy timer and two saturating event counters.

## Interface
Parameters:
- MULT_CYCLES, 5, busy cycles for mult/multu
- DIV_CYCLES, 10, busy cycles for div/divu
- HANDLER_PC, 32'h0000_4180, exception entry address

Ports:
- clk  in  1  core clock
- reset_n  in  1  asynchronous, active-low reset
- hz_stall  in  1  data-hazard stall request from the hazard unit (D stage)
- md_use_d  in  1  D-stage instruction uses the MDU (mult/div/mfhi/mflo/mthi/mtlo)
- mdu_start_e  in  1  mult/div is in E this cycle and starts
- mdu_div_e  in  1  1 = div/divu, 0 = mult/multu; valid with mdu_start_e
- req  in  1  exception/interrupt request from CP0 (M stage)
- eret_m  in  1  eret in M stage
- epc  in  32  EPC value from CP0
- pc_en, fd_en, de_en  out  1  register enables
- fd_flush, de_flush, em_flush, mw_flush  out  1  synchronous clear-to-bubble for each stage register
- next_pc_sel  out  2  0 = sequential/branch, 1 = handler, 2 = EPC
- redirect_pc  out  32  redirect target; 0 when next_pc_sel = 0
- mdu_busy  out  1  MDU occupied
- stall_cnt, flush_cnt  out  32  saturating event counters

## Operation
- Priority of cycle modes: req > eret_m > stall > run.
- MDU FSM has two states, IDLE and BUSY.
  - IDLE with mdu_start_e=1 and req=0 → BUSY. The 4-bit down-counter loads DIV_CYCLES or MULT_CYCLES.
  - BUSY decrements every cycle and returns to IDLE on the edge where the counter equals 1.
  - mdu_start_e while BUSY is ignored; the hazard logic guarantees it does not occur.
  - req in the same cycle as mdu_start_e cancels the start.
  - req while BUSY does not abort the operation.
- mdu_busy = (state == BUSY).
- stall = (hz_stall | (md_use_d & (mdu_start_e | mdu_busy))) & ~req & ~eret_m.
- req mode:
  - pc_en = fd_en = de_en = 1; all four flushes = 1.
  - next_pc_sel = 1; redirect_pc = HANDLER_PC.
  - flush_cnt increments.
- eret mode:
  - Enables = 1; fd_flush = de_flush = em_flush = 1, mw_flush = 0.
  - next_pc_sel = 2; redirect_pc = epc.
  - flush_cnt increments.
- stall mode:
  - pc_en = fd_en = 0; de_en = 1, de_flush = 1 (bubble into E).
  - Other flushes 0, next_pc_sel = 0.
  - stall_cnt increments.
- run mode: all enables 1, all flushes 0, next_pc_sel = 0, redirect_pc = 0.
- Counters saturate at 32'hFFFF_FFFF and do not wrap.

## Timing
- Enable, flush, next_pc_sel and redirect_pc are combinational from the current inputs and registered mdu_busy. They take effect at the next clk edge, with zero added latency.
- mdu_busy rises the cycle after the start edge and stays high for exactly N cycles (N = MULT_CYCLES or DIV_CYCLES).
- Counters update on the clk edge ending the counted cycle.
- While reset_n = 0:
  - MDU FSM = IDLE, counter = 0, mdu_busy = 0, stall_cnt = flush_cnt = 0.
  - pc_en = fd_en = de_en = 0, all flushes 0, next_pc_sel = 0, redirect_pc = 0.
- Reset asserted mid-BUSY clears immediately (asynchronously). Normal operation resumes on the first edge after release.
- req and eret_m together: req mode only; flush_cnt increments by 1.
- hz_stall together with req or eret_m: the stall is suppressed and stall_cnt is unchanged.

## Structure
- Shared package pipe_ctrl_pkg holds:
  - next_pc_sel encodings (PCSEL_SEQ = 0, PCSEL_HANDLER = 1, PCSEL_EPC = 2)
  - the MDU state enum (MDU_IDLE, MDU_BUSY)
  - the default HANDLER_PC
- One sub-module, mdu_busy_timer, contains the MDU FSM and down-counter. It has inputs start, is_div, cancel and outputs busy.
- The mode decode and the counters stay in the top-level module.

## Test plan
- Reset release, all inputs 0 → run values; mdu_busy = 0; stall_cnt = flush_cnt = 0.
- mdu_start_e = 1, mdu_div_e = 1 for one cycle, md_use_d held at 1:
  - mdu_busy high for exactly 10 cycles.
  - pc_en = 0 for 11 cycles (start cycle plus busy).
  - stall_cnt = 11.
- Mult in E plus req in the same cycle:
  - mdu_busy stays 0.
  - All flushes = 1, redirect_pc = 32'h4180, flush_cnt = 1.
- hz_stall = 1 with eret_m = 1, epc = 32'h3010:
  - next_pc_sel = 2, redirect_pc = 32'h3010.
  - mw_flush = 0, stall_cnt unchanged.
- req and eret_m together → handler redirect, mw_flush = 1, flush_cnt +1. Then reset_n pulsed low mid-div → mdu_busy = 0 immediately and both counters read 0.
